// File: rtl/rtc_timekeeper.sv
// rtl/rtc_timekeeper.sv - hh:mm:ss timekeeper with load, 12/24h display, day counter and alarm
module rtc_timekeeper #(
    parameter int SEC_PER_MIN = 60,
    parameter int MIN_PER_HR  = 60,
    parameter int HRS_PER_DAY = 24,
    parameter int DAY_W       = 16
) (
    input  logic             clk_1Hz,
    input  logic             reset,
    input  logic             run,
    input  logic             mode_12h,
    input  logic             load,
    input  logic [4:0]       load_hrs,
    input  logic [5:0]       load_min,
    input  logic [5:0]       load_sec,
    input  logic             alarm_en,
    input  logic             alarm_wr,
    input  logic [4:0]       alarm_hrs_in,
    input  logic [5:0]       alarm_min_in,
    input  logic             alarm_ack,
    output logic [5:0]       sec,
    output logic [5:0]       min,
    output logic [4:0]       hrs,
    output logic [4:0]       disp_hrs,
    output logic             pm,
    output logic             min_tick,
    output logic             hr_tick,
    output logic             day_tick,
    output logic [DAY_W-1:0] day_cnt,
    output logic             load_err,
    output logic             alarm_flag
);

    // Largest legal value of each field; comparing with <= keeps every compare at field width.
    localparam logic [5:0] SEC_MAX = 6'(SEC_PER_MIN - 1);
    localparam logic [5:0] MIN_MAX = 6'(MIN_PER_HR - 1);
    localparam logic [4:0] HRS_MAX = 5'(HRS_PER_DAY - 1);
    localparam logic [DAY_W-1:0] DAY_ONE = {{(DAY_W-1){1'b0}}, 1'b1};

    logic [4:0] alarm_hrs;
    logic [5:0] alarm_min;
    logic       load_ok;
    logic       count;
    logic       sec_wrap;
    logic       min_wrap;
    logic       hrs_wrap;
    logic [5:0] sec_nxt;
    logic [5:0] min_nxt;
    logic [4:0] hrs_nxt;
    logic       alarm_hit;

    // Cascaded increment of the time fields and the alarm match on the time being entered.
    always_comb begin
        load_ok  = (load_sec <= SEC_MAX) && (load_min <= MIN_MAX) && (load_hrs <= HRS_MAX);
        count    = run && !load;
        sec_wrap = (sec == SEC_MAX);
        min_wrap = sec_wrap && (min == MIN_MAX);
        hrs_wrap = min_wrap && (hrs == HRS_MAX);
        sec_nxt  = sec_wrap ? 6'd0 : sec + 6'd1;
        min_nxt  = min_wrap ? 6'd0 : (sec_wrap ? min + 6'd1 : min);
        hrs_nxt  = hrs_wrap ? 5'd0 : (min_wrap ? hrs + 5'd1 : hrs);
        // Seconds land on zero exactly when they wrap; out-of-range alarm fields never equal a legal time.
        alarm_hit = count && alarm_en && sec_wrap
                    && (min_nxt == alarm_min) && (hrs_nxt == alarm_hrs);
    end

    // Time, day counter and one-cycle pulses; load takes priority over counting.
    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            sec      <= 6'd0;
            min      <= 6'd0;
            hrs      <= 5'd0;
            day_cnt  <= '0;
            min_tick <= 1'b0;
            hr_tick  <= 1'b0;
            day_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            min_tick <= 1'b0;
            hr_tick  <= 1'b0;
            day_tick <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    sec <= load_sec;
                    min <= load_min;
                    hrs <= load_hrs;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (run) begin
                sec      <= sec_nxt;
                min      <= min_nxt;
                hrs      <= hrs_nxt;
                min_tick <= sec_wrap;
                hr_tick  <= min_wrap;
                day_tick <= hrs_wrap;
                if (hrs_wrap) begin
                    day_cnt <= day_cnt + DAY_ONE;
                end
            end
        end
    end

    // Alarm registers and sticky flag; a hit outranks an acknowledge on the same edge.
    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            alarm_hrs  <= 5'd0;
            alarm_min  <= 6'd0;
            alarm_flag <= 1'b0;
        end else begin
            if (alarm_wr) begin
                alarm_hrs <= alarm_hrs_in;
                alarm_min <= alarm_min_in;
            end
            if (alarm_hit) begin
                alarm_flag <= 1'b1;
            end else if (alarm_ack) begin
                alarm_flag <= 1'b0;
            end
        end
    end

    // Display formatting straight from the 24h hours register.
    always_comb begin
        disp_hrs = hrs;
        pm       = 1'b0;
        if (mode_12h) begin
            pm = (hrs >= 5'd12);
            if (hrs == 5'd0) begin
                disp_hrs = 5'd12;
            end else if (hrs > 5'd12) begin
                disp_hrs = hrs - 5'd12;
            end
        end
    end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb/tb_rtc_timekeeper.sv - randomized model-checked bench for rtc_timekeeper
module tb_rtc_timekeeper;

    logic       clk_1Hz = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       mode_12h = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_hrs = '0;
    logic [5:0] load_min = '0;
    logic [5:0] load_sec = '0;
    logic       alarm_en = 1'b0;
    logic       alarm_wr = 1'b0;
    logic [4:0] alarm_hrs_in = '0;
    logic [5:0] alarm_min_in = '0;
    logic       alarm_ack = 1'b0;

    logic [5:0]  d_sec, d_min, s_sec, s_min;
    logic [4:0]  d_hrs, d_disp, s_hrs, s_disp;
    logic        d_pm, d_mt, d_ht, d_dt, d_le, d_af;
    logic        s_pm, s_mt, s_ht, s_dt, s_le, s_af;
    logic [15:0] d_dc, s_dc;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk_1Hz = ~clk_1Hz;

    rtc_timekeeper u_def (
        .clk_1Hz(clk_1Hz), .reset(reset), .run(run), .mode_12h(mode_12h),
        .load(load), .load_hrs(load_hrs), .load_min(load_min), .load_sec(load_sec),
        .alarm_en(alarm_en), .alarm_wr(alarm_wr), .alarm_hrs_in(alarm_hrs_in),
        .alarm_min_in(alarm_min_in), .alarm_ack(alarm_ack),
        .sec(d_sec), .min(d_min), .hrs(d_hrs), .disp_hrs(d_disp), .pm(d_pm),
        .min_tick(d_mt), .hr_tick(d_ht), .day_tick(d_dt), .day_cnt(d_dc),
        .load_err(d_le), .alarm_flag(d_af)
    );

    rtc_timekeeper #(.SEC_PER_MIN(4), .MIN_PER_HR(3), .HRS_PER_DAY(2), .DAY_W(16)) u_small (
        .clk_1Hz(clk_1Hz), .reset(reset), .run(run), .mode_12h(mode_12h),
        .load(load), .load_hrs(load_hrs), .load_min(load_min), .load_sec(load_sec),
        .alarm_en(alarm_en), .alarm_wr(alarm_wr), .alarm_hrs_in(alarm_hrs_in),
        .alarm_min_in(alarm_min_in), .alarm_ack(alarm_ack),
        .sec(s_sec), .min(s_min), .hrs(s_hrs), .disp_hrs(s_disp), .pm(s_pm),
        .min_tick(s_mt), .hr_tick(s_ht), .day_tick(s_dt), .day_cnt(s_dc),
        .load_err(s_le), .alarm_flag(s_af)
    );

    // Reference model: time held as seconds-of-day, fields derived arithmetically.
    int spm[2] = '{60, 4};
    int mph[2] = '{60, 3};
    int hpd[2] = '{24, 2};
    int m_t[2]    = '{0, 0};
    int m_day[2]  = '{0, 0};
    int m_mt[2]   = '{0, 0};
    int m_ht[2]   = '{0, 0};
    int m_dt[2]   = '{0, 0};
    int m_le[2]   = '{0, 0};
    int m_af[2]   = '{0, 0};
    int m_ah[2]   = '{0, 0};
    int m_am[2]   = '{0, 0};

    always @(posedge clk_1Hz or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_t[i] = 0; m_day[i] = 0; m_mt[i] = 0; m_ht[i] = 0; m_dt[i] = 0;
                m_le[i] = 0; m_af[i] = 0; m_ah[i] = 0; m_am[i] = 0;
            end else begin
                int hit;
                hit = 0;
                m_mt[i] = 0; m_ht[i] = 0; m_dt[i] = 0; m_le[i] = 0;
                if (load) begin
                    if (int'(load_sec) < spm[i] && int'(load_min) < mph[i] && int'(load_hrs) < hpd[i])
                        m_t[i] = (int'(load_hrs) * mph[i] + int'(load_min)) * spm[i] + int'(load_sec);
                    else
                        m_le[i] = 1;
                end else if (run) begin
                    m_t[i] = (m_t[i] + 1) % (spm[i] * mph[i] * hpd[i]);
                    m_mt[i] = (m_t[i] % spm[i] == 0);
                    m_ht[i] = (m_t[i] % (spm[i] * mph[i]) == 0);
                    m_dt[i] = (m_t[i] == 0);
                    if (m_t[i] == 0) m_day[i] = (m_day[i] + 1) % 65536;
                    if (alarm_en && m_ah[i] < hpd[i] && m_am[i] < mph[i]
                        && m_t[i] == (m_ah[i] * mph[i] + m_am[i]) * spm[i])
                        hit = 1;
                end
                if (hit) m_af[i] = 1;
                else if (alarm_ack) m_af[i] = 0;
                if (alarm_wr) begin
                    m_ah[i] = int'(alarm_hrs_in);
                    m_am[i] = int'(alarm_min_in);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input int a_sec, input int a_min, input int a_hrs,
                            input int a_disp, input int a_pm, input int a_mt, input int a_ht,
                            input int a_dt, input int a_dc, input int a_le, input int a_af);
        int h, e_disp, e_pm;
        h = m_t[i] / (spm[i] * mph[i]);
        e_disp = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
        e_pm   = (mode_12h && h >= 12) ? 1 : 0;
        chk($sformatf("i%0d sec", i), a_sec, m_t[i] % spm[i]);
        chk($sformatf("i%0d min", i), a_min, (m_t[i] / spm[i]) % mph[i]);
        chk($sformatf("i%0d hrs", i), a_hrs, h);
        chk($sformatf("i%0d disp_hrs", i), a_disp, e_disp);
        chk($sformatf("i%0d pm", i), a_pm, e_pm);
        chk($sformatf("i%0d min_tick", i), a_mt, m_mt[i]);
        chk($sformatf("i%0d hr_tick", i), a_ht, m_ht[i]);
        chk($sformatf("i%0d day_tick", i), a_dt, m_dt[i]);
        chk($sformatf("i%0d day_cnt", i), a_dc, m_day[i]);
        chk($sformatf("i%0d load_err", i), a_le, m_le[i]);
        chk($sformatf("i%0d alarm_flag", i), a_af, m_af[i]);
    endtask

    // Per-cycle compare of both instances against the model, well after the rising edge.
    always @(posedge clk_1Hz) begin
        #2;
        cmp_inst(0, d_sec, d_min, d_hrs, d_disp, d_pm, d_mt, d_ht, d_dt, d_dc, d_le, d_af);
        cmp_inst(1, s_sec, s_min, s_hrs, s_disp, s_pm, s_mt, s_ht, s_dt, s_dc, s_le, s_af);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_1Hz);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load = 1'b1; load_hrs = 5'(h); load_min = 6'(m); load_sec = 6'(s);
        tick(1);
        load = 1'b0;
    endtask

    int hr_list[6]   = '{0, 1, 11, 12, 13, 23};
    int disp_list[6] = '{12, 1, 11, 12, 1, 11};
    int pm_list[6]   = '{0, 0, 0, 1, 1, 1};

    initial begin
        int cnt, last;
        tick(2);
        chk("reset sec", d_sec, 0);
        chk("reset day_cnt", d_dc, 0);
        chk("reset alarm_flag", d_af, 0);

        // Full day at default parameters.
        reset = 1'b0; run = 1'b1;
        tick(86400);
        chk("day day_tick", d_dt, 1);
        chk("day day_cnt", d_dc, 1);
        chk("day hrs", d_hrs, 0);
        tick(1);
        chk("day_tick one cycle", d_dt, 0);

        // Valid then invalid load.
        do_load(12, 34, 56);
        chk("load hrs", d_hrs, 12);
        chk("load min", d_min, 34);
        chk("load sec", d_sec, 56);
        load = 1'b1; load_hrs = 5'd24; load_min = 6'd0; load_sec = 6'd0;
        tick(1);
        chk("bad load err", d_le, 1);
        chk("bad load sec", d_sec, 56);
        load = 1'b0;
        tick(1);
        chk("load_err one cycle", d_le, 0);
        chk("count after load", d_sec, 57);

        // 12h display sweep, clock held.
        run = 1'b0; mode_12h = 1'b1;
        for (int k = 0; k < 6; k++) begin
            do_load(hr_list[k], 0, 0);
            #1;
            chk($sformatf("disp12 h%0d", hr_list[k]), d_disp, disp_list[k]);
            chk($sformatf("pm h%0d", hr_list[k]), d_pm, pm_list[k]);
        end
        mode_12h = 1'b0;

        // Alarm: hit beats ack, ack clears next edge, a load never triggers.
        alarm_wr = 1'b1; alarm_hrs_in = 5'd7; alarm_min_in = 6'd30; alarm_en = 1'b1;
        tick(1);
        alarm_wr = 1'b0; run = 1'b1;
        do_load(7, 29, 58);
        tick(1);
        chk("alarm pre flag", d_af, 0);
        alarm_ack = 1'b1;
        tick(1);
        chk("alarm hit over ack", d_af, 1);
        chk("alarm time sec", d_sec, 0);
        tick(1);
        chk("alarm ack clears", d_af, 0);
        alarm_ack = 1'b0;
        do_load(7, 30, 0);
        chk("alarm load no hit", d_af, 0);
        alarm_en = 1'b0;

        // Pause then resume across an hour boundary.
        do_load(10, 59, 59);
        run = 1'b0;
        tick(5);
        chk("pause sec", d_sec, 59);
        chk("pause min_tick", d_mt, 0);
        run = 1'b1;
        tick(1);
        chk("resume hrs", d_hrs, 11);
        chk("resume min", d_min, 0);
        chk("resume min_tick", d_mt, 1);
        chk("resume hr_tick", d_ht, 1);

        // Reduced-parameter instance: one day every 24 edges.
        do_load(0, 0, 0);
        cnt = 0; last = 0;
        for (int k = 0; k < 24; k++) begin
            tick(1);
            cnt += int'(s_dt);
            last = int'(s_dt);
        end
        chk("small day_tick count", cnt, 1);
        chk("small day_tick at 24", last, 1);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            run      = ($urandom_range(0, 7) != 0);
            mode_12h = 1'($urandom_range(0, 1));
            alarm_en = ($urandom_range(0, 3) != 0);
            alarm_ack = ($urandom_range(0, 7) == 0);
            alarm_wr = ($urandom_range(0, 31) == 0);
            alarm_hrs_in = 5'($urandom_range(0, 2));
            alarm_min_in = 6'($urandom_range(0, 3));
            load = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                load_hrs = 5'($urandom_range(0, 31));
                load_min = 6'($urandom_range(0, 63));
                load_sec = 6'($urandom_range(0, 63));
            end else begin
                load_hrs = 5'($urandom_range(0, 1));
                load_min = 6'($urandom_range(0, 2));
                load_sec = 6'($urandom_range(0, 3));
            end
            tick(1);
        end
        load = 1'b0; alarm_wr = 1'b0; alarm_ack = 1'b0; run = 1'b1;
        tick(3);

        // Asynchronous reset mid-count.
        reset = 1'b1;
        #1;
        chk("async rst def sec", d_sec, 0);
        chk("async rst def day_cnt", d_dc, 0);
        chk("async rst small hrs", s_hrs, 0);
        chk("async rst small day_cnt", s_dc, 0);
        chk("async rst small flag", s_af, 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("post rst def sec", d_sec, 1);
        chk("post rst small sec", s_sec, 1);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
